wb_reg_file: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline register: selects the writeback result, commits it to the 32-entry architectural register file, and serves the two decode-stage read ports. Sits between the MEM/WB register outputs and the ID stage. It also drives the writeback result to the EX forwarding mux and counts committed register writes.

---
 rtl/wb_reg_file.sv | 90 +++++++++
 tb/tb_wb_reg_file.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// Writeback stage: result select, 32-entry register file commit, two ID read ports, commit counter.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-to-read bypass on both read ports.
module wb_reg_file #(
    parameter int PC_BITS       = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write_wb,
    input  logic [1:0]               mem_to_reg_wb,
    input  logic [PC_BITS-1:0]       alu_out_wb,
    input  logic [PC_BITS-1:0]       read_data_wb,
    input  logic [PC_BITS-1:0]       pc_plus_4wb,
    input  logic [REG_ADDR_BITS-1:0] write_reg_wb,
    input  logic [REG_ADDR_BITS-1:0] rs_addr_d,
    input  logic [REG_ADDR_BITS-1:0] rt_addr_d,
    output logic [PC_BITS-1:0]       rs_data_d,
    output logic [PC_BITS-1:0]       rt_data_d,
    output logic [PC_BITS-1:0]       result_wb,
    output logic                     commit_wb,
    output logic [31:0]              wb_count
);

    localparam int NUM_REGS = 1 << REG_ADDR_BITS;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    logic [PC_BITS-1:0] regs_q [NUM_REGS];
    logic [31:0]        count_q;
    logic [31:0]        count_d;

    // NOTE: every output of a combinational block gets a value on every path; a missing default infers a latch.
    always_comb begin
        result_wb = alu_out_wb;
        case (wb_sel_e'(mem_to_reg_wb))
            SEL_LOAD: result_wb = read_data_wb;
            SEL_LINK: result_wb = pc_plus_4wb;
            default:  result_wb = alu_out_wb;
        endcase
    end

    assign commit_wb = reg_write_wb && (write_reg_wb != '0);
    assign count_d   = count_q + 32'd1;
    assign wb_count  = count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the array is reset explicitly because a cleared file is architecturally visible after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (commit_wb) begin
            regs_q[write_reg_wb] <= result_wb;
            count_q              <= count_d;
        end
    end

    // Index 0 is forced last so neither the array nor the bypass can leak a value onto r0.
    always_comb begin
        rs_data_d = regs_q[rs_addr_d];
`ifdef REGFILE_BYPASS_EN
        if (commit_wb && (rs_addr_d == write_reg_wb)) begin
            rs_data_d = result_wb;
        end
`endif
        if (rs_addr_d == '0) begin
            rs_data_d = '0;
        end
    end

    always_comb begin
        rt_data_d = regs_q[rt_addr_d];
`ifdef REGFILE_BYPASS_EN
        if (commit_wb && (rt_addr_d == write_reg_wb)) begin
            rt_data_d = result_wb;
        end
`endif
        if (rt_addr_d == '0) begin
            rt_data_d = '0;
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed table-driven bench for wb_reg_file; expectations follow whether REGFILE_BYPASS_EN is defined.
module tb_wb_reg_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_wb;
    logic [1:0]  mem_to_reg_wb;
    logic [31:0] alu_out_wb;
    logic [31:0] read_data_wb;
    logic [31:0] pc_plus_4wb;
    logic [4:0]  write_reg_wb;
    logic [4:0]  rs_addr_d;
    logic [4:0]  rt_addr_d;
    logic [31:0] rs_data_d;
    logic [31:0] rt_data_d;
    logic [31:0] result_wb;
    logic        commit_wb;
    logic [31:0] wb_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    wb_reg_file #(.PC_BITS(32), .REG_ADDR_BITS(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_wb (reg_write_wb),
        .mem_to_reg_wb(mem_to_reg_wb),
        .alu_out_wb   (alu_out_wb),
        .read_data_wb (read_data_wb),
        .pc_plus_4wb  (pc_plus_4wb),
        .write_reg_wb (write_reg_wb),
        .rs_addr_d    (rs_addr_d),
        .rt_addr_d    (rt_addr_d),
        .rs_data_d    (rs_data_d),
        .rt_data_d    (rt_data_d),
        .result_wb    (result_wb),
        .commit_wb    (commit_wb),
        .wb_count     (wb_count)
    );

    // Inputs for one cycle and the outputs expected before that cycle's rising edge.
    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_res;
        logic        e_commit;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        reg_write_wb  = v.we;
        mem_to_reg_wb = v.sel;
        alu_out_wb    = v.alu;
        read_data_wb  = v.ld;
        pc_plus_4wb   = v.pc;
        write_reg_wb  = v.wreg;
        rs_addr_d     = v.rs;
        rt_addr_d     = v.rt;
    endtask

    initial begin
        logic [31:0] byp_7;
        logic [31:0] byp_12;
        byp_7  = BYP ? 32'h22 : 32'h11;
        byp_12 = BYP ? 32'h66 : 32'h0;

        //            rst   we    sel    alu            ld             pc             wreg   rs     rt     e_rs           e_rt           e_res          cm    e_count
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd1,  32'h0,         32'h0,         32'h0,         1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h1234,      32'h0,         32'h0,         5'd5,  5'd31, 5'd1,  32'h0,         32'h0,         32'h1234,      1'b1, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h9,         32'h0,         32'h0,         5'd5,  5'd5,  5'd5,  32'h1234,      32'h1234,      32'h9,         1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h33,        32'hDEADBEEF,  32'h0,         5'd5,  5'd0,  5'd31, 32'h0,         32'h0,         32'hDEADBEEF,  1'b1, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 32'h33,        32'hDEADBEEF,  32'h400008,    5'd5,  5'd1,  5'd0,  32'h0,         32'h0,         32'h400008,    1'b1, 32'd2});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 32'hABCD,      32'h1,         32'h2,         5'd5,  5'd5,  5'd5,  32'h400008,    32'h400008,    32'hABCD,      1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'hFFFFFFFF,  32'h0,         32'h0,         5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'hFFFFFFFF,  1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd5,  32'h0,         32'h400008,    32'h0,         1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h11,        32'h0,         32'h0,         5'd7,  5'd5,  5'd31, 32'h400008,    32'h0,         32'h11,        1'b1, 32'd3});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h22,        32'h0,         32'h0,         5'd7,  5'd7,  5'd7,  byp_7,         byp_7,         32'h22,        1'b1, 32'd4});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd7,  5'd7,  5'd7,  32'h22,        32'h22,        32'h0,         1'b0, 32'd5});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'hAA,        32'h0,         32'h0,         5'd3,  5'd7,  5'd0,  32'h22,        32'h0,         32'hAA,        1'b1, 32'd5});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 32'hBB,        32'h0,         32'h0,         5'd4,  5'd3,  5'd7,  32'hAA,        32'h22,        32'hBB,        1'b1, 32'd6});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd4,  5'd3,  5'd4,  32'h0,         32'h0,         32'h0,         1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h5A,        32'h0,         32'h0,         5'd9,  5'd7,  5'd0,  32'h0,         32'h0,         32'h5A,        1'b1, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd9,  5'd9,  5'd7,  32'h5A,        32'h0,         32'h0,         1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h66,        32'h0,         32'h0,         5'd12, 5'd12, 5'd9,  byp_12,        32'h5A,        32'h66,        1'b1, 32'd1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'h0,         5'd12, 5'd12, 5'd12, 32'h66,        32'h66,        32'h0,         1'b0, 32'd2});

        // Power-up reset: one cycle of rst with a write pending that must be dropped.
        @(negedge clk);
        drive('{1'b1, 1'b1, 2'd0, 32'hCAFE, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 1'b0, 32'd0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d rs_data", i), rs_data_d, vecs[i].e_rs);
            check($sformatf("v%0d rt_data", i), rt_data_d, vecs[i].e_rt);
            check($sformatf("v%0d result", i), result_wb, vecs[i].e_res);
            check($sformatf("v%0d commit", i), {31'd0, commit_wb}, {31'd0, vecs[i].e_commit});
            check($sformatf("v%0d wb_count", i), wb_count, vecs[i].e_count);
        end

        // Long commit stream: count keeps exact pace and the last value written to r21 survives.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst           = 1'b0;
            reg_write_wb  = 1'b1;
            mem_to_reg_wb = 2'd0;
            alu_out_wb    = 32'(i);
            write_reg_wb  = 5'((i % 31) + 1);
        end
        @(negedge clk);
        reg_write_wb = 1'b0;
        rs_addr_d    = 5'd21;
        rt_addr_d    = 5'd0;
        #2;
        check("stream wb_count", wb_count, 32'd302);
        check("stream r21", rs_data_d, 32'd299);
        check("stream r0", rt_data_d, 32'd0);
        check("stream commit idle", {31'd0, commit_wb}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
